primitive_sequencer: RTL and testbench
======================================

# primitive_sequencer

Assembles graphics commands retired by the writeback stage (begin/end primitive, set vertex, set color, transform) into complete triangles and hands them to the GPU stage over a valid/ready handshake. Sits between writeback and the GPU stage. Back-pressures writeback through a stall output so no command is lost while a triangle is pending. Supports triangle lists and triangle strips.

## Interface
Parameters:
- VERTEX_W, 30, width of one packed vertex (`VERTEX_REG_WIDTH`)
- GSR_W, 16, width of graphics state word (`GSR_WIDTH`)
- CNT_W, 8, width of triangle counter

Ports:
- I_CLOCK  in  1  clock; all state updates on negedge, aligned with writeback
- I_LOCK  in  1  reset: one clock; reset is asynchronous and active-low
- I_CmdValid  in  1  command present from writeback
- I_CmdOp  in  3  `CMD_NOP`=0, `CMD_BEGIN`=1, `CMD_VERTEX`=2, `CMD_END`=3, `CMD_COLOR`=4, `CMD_XFORM`=5
- I_CmdPrim  in  1  with BEGIN: `PRIM_LIST`=0, `PRIM_STRIP`=1
- I_CmdData  in  VERTEX_W  vertex payload; GSR payload in [GSR_W-1:0]
- O_CmdReady  out  1  command accepted this edge if valid
- O_GPUStallSignal  out  1  = ~O_CmdReady, to writeback/fetch stall
- O_TriValid  out  1  triangle on O_VertexV1..V3 valid
- I_TriReady  in  1  GPU accepts triangle
- O_VertexV1/V2/V3  out  VERTEX_W each  triangle vertices, oldest in V1
- O_GSRValue  out  GSR_W  last COLOR/XFORM payload
- O_GSRValue_Valid  out  1  one-cycle pulse when O_GSRValue updated
- O_PrimDone  out  1  one-cycle pulse on accepted END
- O_TriCount  out  CNT_W  triangles issued since last BEGIN, saturating
- O_Error  out  1  sticky protocol error

## Operation
- Accept = I_CmdValid & O_CmdReady. NOP accepted, ignored. Unknown op: accepted, sets O_Error.
- States: IDLE (outside primitive), COLLECT (inside, vcnt 0..2), ISSUE (O_TriValid=1).
- IDLE: BEGIN -> latch prim type, vcnt=0, O_TriCount=0, -> COLLECT. VERTEX or END in IDLE: O_Error=1, no other effect.
- COLLECT: VERTEX writes slot vcnt (V1,V2,V3), vcnt++. Third vertex -> ISSUE.
- Strip, after first triangle: VERTEX shifts V1<=V2, V2<=V3, V3<=data -> ISSUE.
- ISSUE: O_CmdReady=0. On I_TriReady: O_TriCount++ (saturate 2^CNT_W-1); list -> vcnt=0; strip -> vcnt stays 2; -> COLLECT.
- END in COLLECT: partial vertices discarded, O_PrimDone pulse, -> IDLE. BEGIN in COLLECT: O_Error=1, restart primitive (vcnt=0, count=0).
- COLOR/XFORM accepted in IDLE or COLLECT: O_GSRValue<=I_CmdData[GSR_W-1:0], O_GSRValue_Valid pulse; vertex slots untouched. Never reordered against triangles (blocked while ISSUE).
- O_Error cleared only by reset.

## Timing
- Reset (I_LOCK=0, asynchronous): state IDLE, all outputs 0 except O_CmdReady=1; O_GPUStallSignal=0. Mid-ISSUE reset drops O_TriValid immediately, triangle lost.
- Third vertex accepted at edge t -> O_TriValid=1 and vertices stable from t until handshake edge.
- Handshake edge h (O_TriValid & I_TriReady) -> O_TriValid=0, O_CmdReady=1 after h.
- Throughput: max one triangle per 2 cycles (strip); O_GPUStallSignal combinational from state only, not from I_TriReady.
- Pulses (O_GSRValue_Valid, O_PrimDone) high exactly one cycle after accept edge.

## Structure
- `global_def.h`: CMD_* opcodes, PRIM_* codes, `VERTEX_REG_WIDTH`, `GSR_WIDTH`, state encodings.
- One sub-module natural: vertex_window (3-slot write/shift register with vcnt), FSM and counters in top.

## Test plan
- List: BEGIN(LIST), VERTEX 1,2,3, I_TriReady=1 -> O_TriValid one cycle, V1..V3=1,2,3, O_TriCount=1.
- Strip: BEGIN(STRIP), VERTEX 1,2,3,4,5 -> triangles (1,2,3),(2,3,4),(3,4,5), count=3, stall high in each ISSUE.
- Back-pressure: I_TriReady=0 for 5 cycles with END pending -> END not accepted, vertices stable, O_PrimDone only after handshake+END.
- Partial: BEGIN, VERTEX 7,8, END -> no O_TriValid, O_PrimDone pulse, state IDLE.
- Errors: VERTEX in IDLE -> O_Error=1, no triangle; COLOR 0x00FF in COLLECT -> O_GSRValue=0x00FF, one-cycle valid pulse, vcnt unchanged.
- Reset while O_TriValid=1 -> all outputs 0 asynchronously, O_CmdReady=1 on release.

Source files
------------

// File: rtl/primitive_sequencer_pkg.sv
// Shared opcodes, primitive codes, widths and state encodings for the
// primitive sequencer and its vertex window.
package primitive_sequencer_pkg;

    localparam int VERTEX_REG_WIDTH = 30;
    localparam int GSR_WIDTH        = 16;

    // Command opcodes retired by writeback
    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_BEGIN  = 3'd1;
    localparam logic [2:0] CMD_VERTEX = 3'd2;
    localparam logic [2:0] CMD_END    = 3'd3;
    localparam logic [2:0] CMD_COLOR  = 3'd4;
    localparam logic [2:0] CMD_XFORM  = 3'd5;

    // Primitive types latched on BEGIN
    localparam logic PRIM_LIST  = 1'b0;
    localparam logic PRIM_STRIP = 1'b1;

    // Sequencer states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_ISSUE   = 2'd2;

    // Vertex window operations issued by the sequencer
    typedef enum logic [1:0] {
        WIN_HOLD  = 2'd0,
        WIN_CLEAR = 2'd1,
        WIN_WRITE = 2'd2,
        WIN_SHIFT = 2'd3
    } win_op_e;

endpackage

// File: rtl/primitive_sequencer_vertex_window.sv
// Three-slot vertex register. WRITE fills slot vcnt in order V1,V2,V3;
// once slot V3 has been written the window is "full" and further vertices
// slide it (strip continuation). CLEAR discards a partial or consumed set.
module primitive_sequencer_vertex_window
    import primitive_sequencer_pkg::*;
#(
    parameter int VERTEX_W = VERTEX_REG_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  win_op_e             win_op,
    input  logic [VERTEX_W-1:0] data,
    output logic [VERTEX_W-1:0] v1,
    output logic [VERTEX_W-1:0] v2,
    output logic [VERTEX_W-1:0] v3,
    output logic [1:0]          vcnt,
    output logic                full
);

    logic [VERTEX_W-1:0] v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [1:0]          vcnt_q, vcnt_d;
    logic                full_q, full_d;

    // Next-state of the slots: slot contents survive CLEAR, only the fill
    // bookkeeping is reset, since stale slots are never presented.
    always_comb begin
        v1_d   = v1_q;
        v2_d   = v2_q;
        v3_d   = v3_q;
        vcnt_d = vcnt_q;
        full_d = full_q;
        case (win_op)
            WIN_CLEAR: begin
                vcnt_d = 2'd0;
                full_d = 1'b0;
            end
            WIN_WRITE: begin
                case (vcnt_q)
                    2'd0:    v1_d = data;
                    2'd1:    v2_d = data;
                    default: v3_d = data;
                endcase
                // vcnt parks at 2 once the third slot is written
                if (vcnt_q == 2'd2) full_d = 1'b1;
                else                vcnt_d = vcnt_q + 2'd1;
            end
            WIN_SHIFT: begin
                v1_d = v2_q;
                v2_d = v3_q;
                v3_d = data;
            end
            default: ;
        endcase
    end

    // Window registers, updated on the falling edge with writeback
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= '0;
            v2_q   <= '0;
            v3_q   <= '0;
            vcnt_q <= 2'd0;
            full_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            vcnt_q <= vcnt_d;
            full_q <= full_d;
        end
    end

    assign v1   = v1_q;
    assign v2   = v2_q;
    assign v3   = v3_q;
    assign vcnt = vcnt_q;
    assign full = full_q;

endmodule

// File: rtl/primitive_sequencer.sv
// Assembles writeback graphics commands into triangles (list or strip) and
// hands them to the GPU stage over valid/ready. While a triangle waits the
// command port is closed so COLOR/XFORM can never overtake geometry.
module primitive_sequencer
    import primitive_sequencer_pkg::*;
#(
    parameter int VERTEX_W = VERTEX_REG_WIDTH,
    parameter int GSR_W    = GSR_WIDTH,
    parameter int CNT_W    = 8
) (
    input  logic                I_CLOCK,
    input  logic                I_LOCK,
    input  logic                I_CmdValid,
    input  logic [2:0]          I_CmdOp,
    input  logic                I_CmdPrim,
    input  logic [VERTEX_W-1:0] I_CmdData,
    output logic                O_CmdReady,
    output logic                O_GPUStallSignal,
    output logic                O_TriValid,
    input  logic                I_TriReady,
    output logic [VERTEX_W-1:0] O_VertexV1,
    output logic [VERTEX_W-1:0] O_VertexV2,
    output logic [VERTEX_W-1:0] O_VertexV3,
    output logic [GSR_W-1:0]    O_GSRValue,
    output logic                O_GSRValue_Valid,
    output logic                O_PrimDone,
    output logic [CNT_W-1:0]    O_TriCount,
    output logic                O_Error
);

    logic [1:0]       state_q, state_d;
    logic             strip_q, strip_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [GSR_W-1:0] gsr_q, gsr_d;
    logic             gsrv_q, gsrv_d;
    logic             done_q, done_d;

    win_op_e          win_op;
    logic [1:0]       vcnt;
    logic             full;
    logic             in_prim;

    assign in_prim = (state_q == ST_COLLECT);

    // Command decode and FSM. ISSUE ignores the command port entirely, so
    // accept is simply "valid while not in ISSUE".
    always_comb begin
        state_d = state_q;
        strip_d = strip_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        gsr_d   = gsr_q;
        gsrv_d  = 1'b0;
        done_d  = 1'b0;
        win_op  = WIN_HOLD;
        if (state_q == ST_ISSUE) begin
            if (I_TriReady) begin
                state_d = ST_COLLECT;
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                // A strip keeps its last two vertices for the next triangle
                win_op = strip_q ? WIN_HOLD : WIN_CLEAR;
            end
        end else if (I_CmdValid) begin
            case (I_CmdOp)
                CMD_NOP: ;
                CMD_BEGIN: begin
                    // Nested BEGIN is an error but still restarts cleanly
                    if (in_prim) err_d = 1'b1;
                    strip_d = I_CmdPrim;
                    cnt_d   = '0;
                    win_op  = WIN_CLEAR;
                    state_d = ST_COLLECT;
                end
                CMD_VERTEX: begin
                    if (!in_prim) begin
                        err_d = 1'b1;
                    end else begin
                        win_op = full ? WIN_SHIFT : WIN_WRITE;
                        if (full || vcnt == 2'd2) state_d = ST_ISSUE;
                    end
                end
                CMD_END: begin
                    if (!in_prim) begin
                        err_d = 1'b1;
                    end else begin
                        win_op  = WIN_CLEAR;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                CMD_COLOR, CMD_XFORM: begin
                    gsr_d  = I_CmdData[GSR_W-1:0];
                    gsrv_d = 1'b1;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Control state, counters and status, updated on the falling edge
    always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            state_q <= ST_IDLE;
            strip_q <= PRIM_LIST;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            gsr_q   <= '0;
            gsrv_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            strip_q <= strip_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            gsr_q   <= gsr_d;
            gsrv_q  <= gsrv_d;
            done_q  <= done_d;
        end
    end

    primitive_sequencer_vertex_window #(
        .VERTEX_W (VERTEX_W)
    ) u_window (
        .clk    (I_CLOCK),
        .rst_n  (I_LOCK),
        .win_op (win_op),
        .data   (I_CmdData),
        .v1     (O_VertexV1),
        .v2     (O_VertexV2),
        .v3     (O_VertexV3),
        .vcnt   (vcnt),
        .full   (full)
    );

    // Handshake outputs depend on state only, never on I_TriReady
    assign O_TriValid       = (state_q == ST_ISSUE);
    assign O_CmdReady       = ~O_TriValid;
    assign O_GPUStallSignal = O_TriValid;
    assign O_GSRValue       = gsr_q;
    assign O_GSRValue_Valid = gsrv_q;
    assign O_PrimDone       = done_q;
    assign O_TriCount       = cnt_q;
    assign O_Error          = err_q;

endmodule

// File: tb/tb_primitive_sequencer.sv
// Bench for primitive_sequencer: directed scenarios with literal
// expectations, then randomized command streams against a queue-based
// model of triangle assembly.
module tb_primitive_sequencer;

    localparam int VW   = 30;
    localparam int GW   = 16;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          I_CLOCK = 1'b0;
    logic          I_LOCK  = 1'b0;
    logic          I_CmdValid = 1'b0;
    logic [2:0]    I_CmdOp    = 3'd0;
    logic          I_CmdPrim  = 1'b0;
    logic [VW-1:0] I_CmdData  = '0;
    logic          I_TriReady = 1'b0;
    logic          O_CmdReady, O_GPUStallSignal, O_TriValid;
    logic [VW-1:0] O_VertexV1, O_VertexV2, O_VertexV3;
    logic [GW-1:0] O_GSRValue;
    logic          O_GSRValue_Valid, O_PrimDone, O_Error;
    logic [CW-1:0] O_TriCount;

    int checks = 0;
    int errors = 0;

    primitive_sequencer #(.VERTEX_W(VW), .GSR_W(GW), .CNT_W(CW)) dut (
        .I_CLOCK          (I_CLOCK),
        .I_LOCK           (I_LOCK),
        .I_CmdValid       (I_CmdValid),
        .I_CmdOp          (I_CmdOp),
        .I_CmdPrim        (I_CmdPrim),
        .I_CmdData        (I_CmdData),
        .O_CmdReady       (O_CmdReady),
        .O_GPUStallSignal (O_GPUStallSignal),
        .O_TriValid       (O_TriValid),
        .I_TriReady       (I_TriReady),
        .O_VertexV1       (O_VertexV1),
        .O_VertexV2       (O_VertexV2),
        .O_VertexV3       (O_VertexV3),
        .O_GSRValue       (O_GSRValue),
        .O_GSRValue_Valid (O_GSRValue_Valid),
        .O_PrimDone       (O_PrimDone),
        .O_TriCount       (O_TriCount),
        .O_Error          (O_Error)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    // ---------------- behavioural model ----------------
    bit            m_open, m_strip, m_pend, m_err, m_gsrv, m_done;
    logic [VW-1:0] m_q[$];
    logic [VW-1:0] m_t[3];
    int            m_cnt;
    logic [GW-1:0] m_gsr;

    function automatic void model_reset();
        m_open = 0; m_strip = 0; m_pend = 0; m_err = 0;
        m_gsrv = 0; m_done = 0; m_cnt = 0; m_gsr = '0;
        m_q.delete();
    endfunction

    function automatic void model_step(bit v, logic [2:0] op, bit prim,
                                       logic [VW-1:0] d, bit tr);
        m_gsrv = 0;
        m_done = 0;
        if (m_pend) begin
            if (tr) begin
                m_pend = 0;
                if (m_cnt < CMAX) m_cnt++;
            end
        end else if (v) begin
            case (op)
                3'd0: ;
                3'd1: begin
                    if (m_open) m_err = 1;
                    m_open = 1; m_strip = prim; m_cnt = 0;
                    m_q.delete();
                end
                3'd2: begin
                    if (!m_open) m_err = 1;
                    else begin
                        m_q.push_back(d);
                        if (m_q.size() == 3) begin
                            m_t[0] = m_q[0]; m_t[1] = m_q[1]; m_t[2] = m_q[2];
                            m_pend = 1;
                            if (m_strip) void'(m_q.pop_front());
                            else         m_q.delete();
                        end
                    end
                end
                3'd3: begin
                    if (!m_open) m_err = 1;
                    else begin
                        m_open = 0; m_done = 1;
                        m_q.delete();
                    end
                end
                3'd4, 3'd5: begin
                    m_gsr = d[GW-1:0]; m_gsrv = 1;
                end
                default: m_err = 1;
            endcase
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("ready", 64'(O_CmdReady), 64'(!m_pend));
        chk("stall", 64'(O_GPUStallSignal), 64'(m_pend));
        chk("tri_valid", 64'(O_TriValid), 64'(m_pend));
        if (m_pend) begin
            chk("v1", 64'(O_VertexV1), 64'(m_t[0]));
            chk("v2", 64'(O_VertexV2), 64'(m_t[1]));
            chk("v3", 64'(O_VertexV3), 64'(m_t[2]));
        end
        chk("gsr", 64'(O_GSRValue), 64'(m_gsr));
        chk("gsr_valid", 64'(O_GSRValue_Valid), 64'(m_gsrv));
        chk("prim_done", 64'(O_PrimDone), 64'(m_done));
        chk("tri_count", 64'(O_TriCount), 64'(m_cnt));
        chk("error", 64'(O_Error), 64'(m_err));
    endtask

    // One command slot: inputs driven just after the rising edge, DUT
    // updates on the falling edge, outputs compared after the next rise.
    task automatic cyc(bit v, logic [2:0] op, bit prim, logic [VW-1:0] d, bit tr);
        I_CmdValid = v; I_CmdOp = op; I_CmdPrim = prim; I_CmdData = d; I_TriReady = tr;
        model_step(v, op, prim, d, tr);
        @(negedge I_CLOCK);
        @(posedge I_CLOCK);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        I_LOCK = 1'b0;
        I_CmdValid = 0; I_TriReady = 0;
        model_reset();
        repeat (2) @(posedge I_CLOCK);
        #1;
        I_LOCK = 1'b1;
        check_all();
    endtask

    task automatic vtx(logic [VW-1:0] d);
        cyc(1, 3'd2, 0, d, 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_ready", 64'(O_CmdReady), 64'd1);
        chk("rst_tri_count", 64'(O_TriCount), 64'd0);

        // Triangle list
        cyc(1, 3'd1, 0, '0, 0);
        vtx(1); vtx(2); vtx(3);
        chk("list_valid", 64'(O_TriValid), 64'd1);
        chk("list_v1", 64'(O_VertexV1), 64'd1);
        chk("list_v3", 64'(O_VertexV3), 64'd3);
        cyc(0, 3'd0, 0, '0, 1);
        chk("list_count", 64'(O_TriCount), 64'd1);
        chk("list_valid_drop", 64'(O_TriValid), 64'd0);
        cyc(1, 3'd3, 0, '0, 0);

        // Triangle strip: (1,2,3),(2,3,4),(3,4,5)
        cyc(1, 3'd1, 1, '0, 0);
        vtx(1); vtx(2); vtx(3);
        chk("strip_t1_v1", 64'(O_VertexV1), 64'd1);
        chk("strip_stall", 64'(O_GPUStallSignal), 64'd1);
        cyc(0, 3'd0, 0, '0, 1);
        vtx(4);
        chk("strip_t2_v1", 64'(O_VertexV1), 64'd2);
        chk("strip_t2_v3", 64'(O_VertexV3), 64'd4);
        cyc(0, 3'd0, 0, '0, 1);
        vtx(5);
        chk("strip_t3_v1", 64'(O_VertexV1), 64'd3);
        chk("strip_t3_v3", 64'(O_VertexV3), 64'd5);
        cyc(0, 3'd0, 0, '0, 1);
        chk("strip_count", 64'(O_TriCount), 64'd3);
        cyc(1, 3'd3, 0, '0, 0);

        // Back-pressure with END pending
        cyc(1, 3'd1, 0, '0, 0);
        vtx(30'h11); vtx(30'h22); vtx(30'h33);
        repeat (5) begin
            cyc(1, 3'd3, 0, '0, 0);
            chk("bp_v2", 64'(O_VertexV2), 64'h22);
            chk("bp_done", 64'(O_PrimDone), 64'd0);
        end
        cyc(1, 3'd3, 0, '0, 1);
        chk("bp_done_hs", 64'(O_PrimDone), 64'd0);
        cyc(1, 3'd3, 0, '0, 0);
        chk("bp_done_end", 64'(O_PrimDone), 64'd1);

        // Partial primitive
        cyc(1, 3'd1, 0, '0, 0);
        vtx(7); vtx(8);
        cyc(1, 3'd3, 0, '0, 0);
        chk("partial_done", 64'(O_PrimDone), 64'd1);
        chk("partial_valid", 64'(O_TriValid), 64'd0);
        cyc(0, 3'd0, 0, '0, 0);
        chk("partial_done_pulse", 64'(O_PrimDone), 64'd0);

        // Errors and GSR update in the middle of a primitive
        vtx(9);
        chk("err_vtx_idle", 64'(O_Error), 64'd1);
        chk("err_no_tri", 64'(O_TriValid), 64'd0);
        cyc(1, 3'd1, 0, '0, 0);
        vtx(9);
        cyc(1, 3'd4, 0, 30'h00FF, 0);
        chk("gsr_val", 64'(O_GSRValue), 64'hFF);
        chk("gsr_pulse", 64'(O_GSRValue_Valid), 64'd1);
        cyc(0, 3'd0, 0, '0, 0);
        chk("gsr_pulse_end", 64'(O_GSRValue_Valid), 64'd0);
        vtx(10); vtx(11);
        chk("gsr_keep_v1", 64'(O_VertexV1), 64'd9);
        chk("gsr_keep_v3", 64'(O_VertexV3), 64'd11);

        // Asynchronous reset while a triangle is offered
        #2 I_LOCK = 1'b0;
        #1;
        chk("arst_tri_valid", 64'(O_TriValid), 64'd0);
        chk("arst_ready", 64'(O_CmdReady), 64'd1);
        chk("arst_error", 64'(O_Error), 64'd0);
        chk("arst_gsr", 64'(O_GSRValue), 64'd0);
        do_reset();

        // Randomized command streams
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            for (int n = 0; n < 250; n++) begin
                int unsigned r;
                logic [2:0]  op;
                logic [VW-1:0] d;
                r = $urandom_range(0, 63);
                if      (r < 36) op = 3'd2;
                else if (r < 40) op = 3'd1;
                else if (r < 44) op = 3'd3;
                else if (r < 50) op = 3'd4;
                else if (r < 55) op = 3'd5;
                else if (r < 63) op = 3'd0;
                else             op = 3'($urandom_range(6, 7));
                d = VW'($urandom());
                cyc($urandom_range(0, 9) < 8, op, 1'($urandom()), d,
                    $urandom_range(0, 1) == 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
